mmio_read_mux: RTL and testbench

MMIO_READ_MUX -- requirements
Module: mmio_read_mux

---
 rtl/mmio_read_mux.sv | 156 +++++++++++++++
 tb/tb_mmio_read_mux.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_read_mux.sv
// mmio_read_mux: single-outstanding MMIO read multiplexer.
// A read request latches a source index from the top bits of rd_addr, then
// waits for that source to signal ready (or for a timeout) and returns one
// registered response pulse.
//
// Ports:
//   clk         single clock, rising edge
//   reset       asynchronous reset, active low
//   rd_req      read request, sampled only while idle
//   rd_addr     read address; index field is rd_addr[AW-1 -: log2(NSRC)]
//   src_data    packed source data, source i at [i*DW +: DW]
//   src_ready   per-source data valid (ignored for synchronised sources)
//   rd_busy     high while a read is outstanding
//   rd_valid    one-cycle response pulse
//   rd_data     response data, held between responses
//   rd_err      timeout flag, qualified by rd_valid
//   src_strobe  one-hot pulse to the source whose read completed successfully
module mmio_read_mux #(
    parameter int unsigned     DW        = 16,
    parameter int unsigned     NSRC      = 4,
    parameter int unsigned     AW        = 9,
    parameter int unsigned     TIMEOUT   = 15,
    parameter logic [NSRC-1:0] SYNC_MASK = NSRC'(2)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rd_req,
    input  logic [AW-1:0]        rd_addr,
    input  logic [NSRC*DW-1:0]   src_data,
    input  logic [NSRC-1:0]      src_ready,
    output logic                 rd_busy,
    output logic                 rd_valid,
    output logic [DW-1:0]        rd_data,
    output logic                 rd_err,
    output logic [NSRC-1:0]      src_strobe
);

    localparam int unsigned IDX_W = $clog2(NSRC);
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Per-source effective data/ready after optional synchronisation
    logic [DW-1:0]   eff_data [NSRC];
    logic [NSRC-1:0] eff_ready;

    for (genvar i = 0; i < NSRC; i++) begin : g_src
        if (SYNC_MASK[i]) begin : g_sync
            // Asynchronous source: 2-flop synchroniser, always considered ready
            logic [DW-1:0] meta;
            logic [DW-1:0] stable;

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    meta   <= '0;
                    stable <= '0;
                end else begin
                    meta   <= src_data[i*DW +: DW];
                    stable <= meta;
                end
            end

            assign eff_data[i]  = stable;
            assign eff_ready[i] = 1'b1;
        end else begin : g_direct
            assign eff_data[i]  = src_data[i*DW +: DW];
            assign eff_ready[i] = src_ready[i];
        end
    end

    // Low address bits and ready of synchronised sources do not affect the response
    logic unused_inputs;
    assign unused_inputs = ^{rd_addr[AW-IDX_W-1:0], src_ready & SYNC_MASK};

    logic [0:0]       state, state_n;
    logic [IDX_W-1:0] idx, idx_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    logic             busy_n;
    logic             valid_n;
    logic             err_n;
    logic [DW-1:0]    data_n;
    logic [NSRC-1:0]  strobe_n;
    logic             sel_ready;
    logic [DW-1:0]    sel_data;

    assign sel_ready = eff_ready[idx];
    assign sel_data  = eff_data[idx];

    // State and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            idx        <= '0;
            cnt        <= '0;
            rd_busy    <= 1'b0;
            rd_valid   <= 1'b0;
            rd_err     <= 1'b0;
            rd_data    <= '0;
            src_strobe <= '0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            cnt        <= cnt_n;
            rd_busy    <= busy_n;
            rd_valid   <= valid_n;
            rd_err     <= err_n;
            rd_data    <= data_n;
            src_strobe <= strobe_n;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        cnt_n    = cnt;
        valid_n  = 1'b0;
        err_n    = 1'b0;
        data_n   = rd_data;
        strobe_n = '0;

        case (state)
            S_IDLE: begin
                if (rd_req) begin
                    state_n = S_WAIT;
                    idx_n   = rd_addr[AW-1 -: IDX_W];
                    cnt_n   = '0;
                end
            end
            S_WAIT: begin
                // Ready wins over timeout when both occur on the same edge
                if (sel_ready) begin
                    state_n  = S_IDLE;
                    valid_n  = 1'b1;
                    data_n   = sel_data;
                    strobe_n = NSRC'(1) << idx;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_n = S_IDLE;
                    valid_n = 1'b1;
                    err_n   = 1'b1;
                    data_n  = '0;
                    cnt_n   = '0;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_n = S_IDLE;
            end
        endcase

        busy_n = (state_n == S_WAIT);
    end

endmodule

// File: tb/tb_mmio_read_mux.sv
// tb_mmio_read_mux: scoreboard bench for mmio_read_mux
// (DW=16, NSRC=4, AW=9, TIMEOUT=4, SYNC_MASK=4'b0010).
module tb_mmio_read_mux;

    typedef struct packed {
        logic [15:0] data;
        logic        err;
        logic [3:0]  strobe;
    } resp_t;

    logic        clk;
    logic        reset;
    logic        rd_req;
    logic [8:0]  rd_addr;
    logic [63:0] src_data;
    logic [3:0]  src_ready;
    logic        rd_busy;
    logic        rd_valid;
    logic [15:0] rd_data;
    logic        rd_err;
    logic [3:0]  src_strobe;

    logic [15:0] slot [4];
    assign src_data = {slot[3], slot[2], slot[1], slot[0]};

    resp_t exp_q [$];
    int    errors    = 0;
    int    checks    = 0;
    int    busy_cnt  = 0;
    int    cyc       = 0;
    int    prev_cyc  = -1;
    bit    b2b       = 1'b0;

    mmio_read_mux #(
        .DW        (16),
        .NSRC      (4),
        .AW        (9),
        .TIMEOUT   (4),
        .SYNC_MASK (4'b0010)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .src_data   (src_data),
        .src_ready  (src_ready),
        .rd_busy    (rd_busy),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .rd_err     (rd_err),
        .src_strobe (src_strobe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Response monitor: every rd_valid pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (rd_busy) busy_cnt++;
        if (rd_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_valid", 32'(rd_valid), 32'd0);
            end else begin
                resp_t e;
                e = exp_q.pop_front();
                check("rd_data", 32'(rd_data), 32'(e.data));
                check("rd_err", 32'(rd_err), 32'(e.err));
                check("src_strobe", 32'(src_strobe), 32'(e.strobe));
            end
            if (b2b) begin
                if (prev_cyc >= 0) check("b2b_gap", 32'(cyc - prev_cyc), 32'd2);
                prev_cyc = cyc;
            end
        end else if (reset) begin
            if (src_strobe != 4'd0) check("idle_strobe", 32'(src_strobe), 32'd0);
            if (rd_err) check("idle_err", 32'(rd_err), 32'd0);
        end
    end

    task automatic drain(input string tag);
        int n = 0;
        while (exp_q.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check({tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
    endtask

    // Issue a one-cycle request and queue its expected response
    task automatic issue(input logic [8:0] addr, input resp_t e);
        @(posedge clk);
        #1;
        rd_req  = 1'b1;
        rd_addr = addr;
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, 32'(rd_busy), 32'd0);
        check({tag, "_valid"}, 32'(rd_valid), 32'd0);
        check({tag, "_data"}, 32'(rd_data), 32'd0);
        check({tag, "_err"}, 32'(rd_err), 32'd0);
        check({tag, "_strobe"}, 32'(src_strobe), 32'd0);
    endtask

    initial begin
        reset     = 1'b0;
        rd_req    = 1'b0;
        rd_addr   = '0;
        src_ready = 4'b0000;
        slot[0]   = 16'hABCD;
        slot[1]   = 16'h0000;
        slot[2]   = 16'h1234;
        slot[3]   = 16'h5555;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk);
        #1;
        reset = 1'b1;

        // Immediate read; low address bits are don't-care
        src_ready[0] = 1'b1;
        issue(9'h005, '{data: 16'hABCD, err: 1'b0, strobe: 4'b0001});
        drain("immediate");

        // Synchronised source: request on the edge of the change sees old value
        @(posedge clk);
        #1;
        slot[1] = 16'h00FF;
        rd_req  = 1'b1;
        rd_addr = 9'h080;
        exp_q.push_back('{data: 16'h0000, err: 1'b0, strobe: 4'b0010});
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        drain("sync_old");
        issue(9'h080, '{data: 16'h00FF, err: 1'b0, strobe: 4'b0010});
        drain("sync_new");

        // Wait states, with an ignored request pulse while busy
        @(posedge clk);
        #1;
        busy_cnt = 0;
        rd_req   = 1'b1;
        rd_addr  = 9'h100;
        exp_q.push_back('{data: 16'h1234, err: 1'b0, strobe: 4'b0100});
        @(posedge clk);
        #1;
        rd_addr = 9'h000;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(posedge clk);
        #1;
        src_ready[2] = 1'b1;
        drain("wait");
        check("wait_busy_cycles", 32'(busy_cnt), 32'd3);
        src_ready[2] = 1'b0;
        repeat (4) @(negedge clk);

        // Reset mid-wait aborts silently, rd_data cleared
        @(posedge clk);
        #1;
        rd_req  = 1'b1;
        rd_addr = 9'h180;
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        @(negedge clk);
        check("abort_busy_before", 32'(rd_busy), 32'd1);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check_all_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        repeat (10) @(negedge clk);
        check("abort_busy_after", 32'(rd_busy), 32'd0);
        issue(9'h000, '{data: 16'hABCD, err: 1'b0, strobe: 4'b0001});
        drain("after_abort");

        // Timeout
        @(posedge clk);
        #1;
        busy_cnt = 0;
        rd_req   = 1'b1;
        rd_addr  = 9'h180;
        exp_q.push_back('{data: 16'h0000, err: 1'b1, strobe: 4'b0000});
        @(posedge clk);
        #1;
        rd_req = 1'b0;
        drain("timeout");
        check("timeout_busy_cycles", 32'(busy_cnt), 32'd4);

        // Back-to-back reads with rd_req held high
        slot[0] = 16'h0F0F;
        @(posedge clk);
        #1;
        b2b      = 1'b1;
        prev_cyc = -1;
        rd_req   = 1'b1;
        rd_addr  = 9'h000;
        for (int i = 0; i < 4; i++) exp_q.push_back('{data: 16'h0F0F, err: 1'b0, strobe: 4'b0001});
        repeat (7) @(posedge clk);
        #1;
        rd_req = 1'b0;
        drain("b2b");
        repeat (6) @(negedge clk);
        b2b = 1'b0;
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_busy", 32'(rd_busy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
